// File: rtl/uart_pkg.sv
// UART shared definitions: frame state encoding, data width, idle line level.
// Used by both the transmitter and the receiver side of the serial link.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // The serial line rests high between frames.
    localparam logic UART_IDLE_LVL = 1'b1;

    // Start bit level is the opposite of the idle level.
    localparam logic UART_START_LVL = ~UART_IDLE_LVL;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(
        input logic [UART_DATA_W-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1, flags the last cycle of a bit.
// Ports: clk_i, rst_ni (async low), clr_i (restart at 0), bit_end_o.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = (cnt_q == LAST);

    // Wrap at the end of a bit so consecutive bits need no extra clear.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Ports: sys_clk, rst_n (async low), tx_data[7:0], tx_req -> txd, tx_busy, tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_req,
    output logic                   txd,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    if (BAUD_DIV < 4) begin : g_bad_baud_div
        $error("uart_tx: CLK_FREQ/BAUD must be at least 4");
    end

    uart_state_e            state_q;
    logic [UART_DATA_W-1:0] shreg_q;
    logic [2:0]             bit_idx_q;
    logic                   txd_q;
    logic                   busy_q;
    logic                   done_q;

    logic bit_end;
    logic cnt_clr;

    // Hold the counter at zero while idle so every bit starts aligned
    // with the state entry; inside a frame it wraps on its own.
    assign cnt_clr = (state_q == ST_IDLE);

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk_i     (sys_clk),
        .rst_ni    (rst_n),
        .clr_i     (cnt_clr),
        .bit_end_o (bit_end)
    );

    // Outputs are registered from the next state, so txd and tx_busy
    // change on the same edge that accepts the request.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= UART_IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (tx_req) begin
                        shreg_q   <= tx_data;
                        bit_idx_q <= '0;
                        txd_q     <= UART_START_LVL;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        txd_q  <= UART_IDLE_LVL;
                        busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        txd_q     <= shreg_q[0];
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= even_parity(shreg_q);
                            state_q <= ST_PARITY;
`else
                            txd_q   <= UART_IDLE_LVL;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shreg_q[bit_idx_q + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        txd_q   <= UART_IDLE_LVL;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        txd_q   <= UART_IDLE_LVL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    txd_q   <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at 50 MHz / 115200 baud (434 clocks per bit).
// Frames are checked bit by bit against a byte-to-frame reference model.
module tb_uart_tx;

    localparam int DIV = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * DIV;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req  = 1'b0;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         busy_at;
        logic [7:0] busy_d;
    } vec_t;

    vec_t vecs[3];

    always #5 sys_clk = ~sys_clk;

    uart_tx #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .txd     (txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: index 0 is the start bit, then LSB-first data,
    // optional even parity, then the stop bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] f;
        int ones;
        int b;
        f = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = (int'(d) / (1 << i)) % 2;
            f[i + 1] = (b == 1);
            ones += b;
        end
`ifdef UART_TX_PARITY_EN
        f[9] = ((ones % 2) == 1);
        f[10] = 1'b1;
`else
        f[9] = 1'b1;
`endif
        return f;
    endfunction

    // Request a frame and follow it to the tx_done cycle.
    task automatic send_frame(input logic [7:0] d, input logic hold,
                              input int busy_at, input logic [7:0] busy_d,
                              input string tag, output logic par_seen);
        logic [15:0] exp;
        int bad;
        int busy_bad;
        int done_bad;
        int t;
        exp = frame_bits(d);
        par_seen = 1'bx;
        tx_data = d;
        tx_req = 1'b1;
        @(negedge sys_clk);
        if (!hold) tx_req = 1'b0;
        tx_data = 8'($urandom);
        busy_bad = 0;
        done_bad = 0;
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
                t = b * DIV + c;
                if (txd !== exp[b]) bad++;
                if (tx_busy !== 1'b1) busy_bad++;
                if (tx_done !== 1'b0) done_bad++;
                if (b == 9 && c == DIV / 2) par_seen = txd;
                if (!hold && busy_at >= 0) begin
                    if (t == busy_at) begin
                        tx_req = 1'b1;
                        tx_data = busy_d;
                    end else if (t == busy_at + 1) begin
                        tx_req = 1'b0;
                        tx_data = 8'($urandom);
                    end
                end
                @(negedge sys_clk);
            end
            chk($sformatf("%s bit%0d bad_cycles", tag, b), bad, 0);
        end
        chk({tag, " busy_drop_cycles"}, busy_bad, 0);
        chk({tag, " early_done_cycles"}, done_bad, 0);
        chk({tag, " done_pulse"}, tx_done, 1);
        chk({tag, " busy_in_done"}, tx_busy, 0);
        chk({tag, " txd_in_done"}, txd, 1);
    endtask

    initial begin
        logic par;
        int dn;

        vecs[0] = '{data: 8'hA5, par: 1'b0, busy_at: 2000, busy_d: 8'h3C};
        vecs[1] = '{data: 8'h07, par: 1'b1, busy_at: -1, busy_d: 8'h00};
        vecs[2] = '{data: 8'h03, par: 1'b0, busy_at: 300, busy_d: 8'hFF};

        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset txd", txd, 1);
        chk("reset busy", tx_busy, 0);
        chk("reset done", tx_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 3; i++) begin
            send_frame(vecs[i].data, 1'b0, vecs[i].busy_at, vecs[i].busy_d,
                       $sformatf("vec%0d", i), par);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("vec%0d parity", i), par, vecs[i].par);
`endif
            dn = 0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge sys_clk);
                if (tx_done !== 1'b0 || tx_busy !== 1'b0 || txd !== 1'b1)
                    dn++;
            end
            chk($sformatf("vec%0d idle_after", i), dn, 0);
        end

        send_frame(8'h00, 1'b1, -1, 8'h00, "held0", par);
        send_frame(8'h00, 1'b1, -1, 8'h00, "held1", par);
        tx_req = 1'b0;
        @(negedge sys_clk);
        chk("held stop busy", tx_busy, 0);
        chk("held stop txd", txd, 1);

        tx_data = 8'h00;
        tx_req = 1'b1;
        @(negedge sys_clk);
        tx_req = 1'b0;
        repeat (DIV * 4 + 100) @(negedge sys_clk);
        chk("pre_reset txd", txd, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset txd", txd, 1);
        chk("async reset busy", tx_busy, 0);
        dn = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (tx_done !== 1'b0) dn++;
        end
        rst_n = 1'b1;
        repeat (DIV * 2) begin
            @(negedge sys_clk);
            if (tx_done !== 1'b0 || txd !== 1'b1) dn++;
        end
        chk("no done after abort", dn, 0);
        send_frame(8'h01, 1'b0, -1, 8'h00, "after_reset", par);
        @(negedge sys_clk);

        for (int i = 0; i < 3; i++) begin
            send_frame(8'($urandom), 1'b0, int'($urandom_range(10, FLEN - 10)),
                       8'($urandom), $sformatf("rnd%0d", i), par);
            repeat (int'($urandom_range(1, 20))) @(negedge sys_clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
